// File: rtl/stp_loader_if.sv
// Handshake and memory-port bundle for the store-polynomial loader.
// The driver side (instruction decoder, stream source, FIFOs) uses the master
// modport; the loader itself uses the slave modport.
interface stp_loader_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_SLOTS = 8,
  parameter int MAX_DEG   = 10
);
  localparam int MAX_COEF = MAX_DEG + 1;
  localparam int AW       = $clog2(NUM_SLOTS * MAX_COEF);
  localparam int SW       = $clog2(NUM_SLOTS) + 1;
  localparam int DW       = $clog2(MAX_DEG + 1) + 1;

  logic                 start;
  logic [SW-1:0]        A;
  logic [DW-1:0]        N;
  logic [WORD_SIZE-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic                 s_wr_en;
  logic [AW-1:0]        s_wr_addr;
  logic [WORD_SIZE-1:0] s_wr_data;
  logic                 n_wr_en;
  logic [SW-2:0]        n_wr_addr;
  logic [DW-1:0]        n_wr_data;
  logic                 res_full;
  logic                 stat_full;
  logic                 res_wr_en;
  logic                 stat_wr_en;
  logic [31:0]          result;
  logic [31:0]          status;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, A, N, din, din_valid, res_full, stat_full,
    input  din_ready, s_wr_en, s_wr_addr, s_wr_data, n_wr_en, n_wr_addr,
           n_wr_data, res_wr_en, stat_wr_en, result, status, slot_valid,
           busy, done
  );

  modport slave (
    input  start, A, N, din, din_valid, res_full, stat_full,
    output din_ready, s_wr_en, s_wr_addr, s_wr_data, n_wr_en, n_wr_addr,
           n_wr_data, res_wr_en, stat_wr_en, result, status, slot_valid,
           busy, done
  );
endinterface

// File: rtl/stp_loader.sv
// Store-polynomial engine: validates slot/degree, streams N+1 coefficients
// into the S RAM slot, records the degree in the N RAM, tracks which slots
// hold a committed polynomial and reports result/status to the output FIFOs.
module stp_loader #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_SLOTS = 8,
  parameter int MAX_DEG   = 10
) (
  input logic         clk,
  input logic         rst,
  stp_loader_if.slave bus
);
  localparam int MAX_COEF = MAX_DEG + 1;
  localparam int AW       = $clog2(NUM_SLOTS * MAX_COEF);
  localparam int SW       = $clog2(NUM_SLOTS) + 1;
  localparam int DW       = $clog2(MAX_DEG + 1) + 1;

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, COMMIT, REPORT, DONE} state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [SW-1:0]        r_a;
  logic [DW-1:0]        r_n;
  logic [AW-1:0]        r_base;
  logic [DW-1:0]        r_cnt;
  logic                 r_s_wr_en;
  logic [AW-1:0]        r_s_wr_addr;
  logic [WORD_SIZE-1:0] r_s_wr_data;
  logic                 r_n_wr_en;
  logic [SW-2:0]        r_n_wr_addr;
  logic [DW-1:0]        r_n_wr_data;
  logic [31:0]          r_result;
  logic [31:0]          r_status;
  logic [NUM_SLOTS-1:0] r_slot_valid;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_fire;
  logic                 w_bad_slot;
  logic                 w_bad_deg;

  // The slot check is evaluated before the degree check, so a bad slot wins.
  assign w_bad_slot = (r_a >= SW'(NUM_SLOTS));
  assign w_bad_deg  = (r_n > DW'(MAX_DEG));
  assign w_accept   = (r_state == LOAD) && bus.din_valid;
  assign w_last     = w_accept && (r_cnt == r_n);
  // Both FIFOs are written together or not at all.
  assign w_fire     = (r_state == REPORT) && !bus.res_full && !bus.stat_full;

  assign bus.din_ready  = (r_state == LOAD);
  assign bus.busy       = (r_state != IDLE);
  assign bus.res_wr_en  = w_fire;
  assign bus.stat_wr_en = w_fire;
  assign bus.s_wr_en    = r_s_wr_en;
  assign bus.s_wr_addr  = r_s_wr_addr;
  assign bus.s_wr_data  = r_s_wr_data;
  assign bus.n_wr_en    = r_n_wr_en;
  assign bus.n_wr_addr  = r_n_wr_addr;
  assign bus.n_wr_data  = r_n_wr_data;
  assign bus.result     = r_result;
  assign bus.status     = r_status;
  assign bus.slot_valid = r_slot_valid;
  assign bus.done       = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = CHECK;
      CHECK:   w_next_state = (w_bad_slot || w_bad_deg) ? REPORT : LOAD;
      LOAD:    if (w_last) w_next_state = COMMIT;
      COMMIT:  w_next_state = REPORT;
      REPORT:  if (w_fire) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand latch, address generation, RAM write ports and report data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a          <= '0;
      r_n          <= '0;
      r_base       <= '0;
      r_cnt        <= '0;
      r_s_wr_en    <= 1'b0;
      r_s_wr_addr  <= '0;
      r_s_wr_data  <= '0;
      r_n_wr_en    <= 1'b0;
      r_n_wr_addr  <= '0;
      r_n_wr_data  <= '0;
      r_result     <= 32'd0;
      r_status     <= 32'hFFFF_FFFF;
      r_slot_valid <= '0;
      r_done       <= 1'b0;
    end else begin
      r_s_wr_en <= 1'b0;
      r_n_wr_en <= 1'b0;
      r_done    <= w_fire;
      if (r_state == IDLE && bus.start) begin
        r_a <= bus.A;
        r_n <= bus.N;
      end
      if (r_state == CHECK) begin
        r_cnt  <= '0;
        r_base <= AW'(r_a) * AW'(MAX_COEF);
        if (w_bad_slot) begin
          r_status <= 32'd3;
          r_result <= 32'd0;
        end else if (w_bad_deg) begin
          r_status <= 32'd2;
          r_result <= 32'd0;
        end
      end
      if (w_accept) begin
        r_s_wr_en   <= 1'b1;
        r_s_wr_addr <= r_base + AW'(r_cnt);
        r_s_wr_data <= bus.din;
        r_cnt       <= r_cnt + DW'(1);
      end
      // Commit side effects land on the edge into COMMIT so they coincide
      // with the final coefficient write.
      if (w_last) begin
        r_n_wr_en                   <= 1'b1;
        r_n_wr_addr                 <= r_a[SW-2:0];
        r_n_wr_data                 <= r_n;
        r_slot_valid[r_a[SW-2:0]]   <= 1'b1;
        r_status                    <= 32'd0;
        r_result                    <= 32'(r_n) + 32'd1;
      end
    end
  end
endmodule
